if_fetch_unit: RTL and testbench

Instruction-fetch reader that sits between the program counter register and the instruction memory. It consumes the current PC, issues in-order read requests to instruction memory over a valid/ready interface, and buffers the returned words. It delivers {pc, inst} pairs to the IF/ID stage under valid/ready. It drives the stall input of the PC register, so the PC advances only when a fetch is actually accepted.

---
 rtl/if_fetch_unit_if.sv | 35 +++
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: signal bundle around the instruction-fetch reader.
// Groups the PC-register handshake (curr_pc, flush, pc_hazarded), the
// instruction-memory request/response channel (imem_req_*, imem_rsp_*) and the
// IF/ID output channel (id_valid, id_ready, id_pc, id_inst).
//   master : the fetch unit's view (drives requests, stall and IF/ID outputs)
//   slave  : the surrounding pipeline / memory view
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] curr_pc;
    logic              flush;
    logic              pc_hazarded;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;

    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;

    modport master (
        input  curr_pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        output pc_hazarded, imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
    );

    modport slave (
        output curr_pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        input  pc_hazarded, imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: in-order instruction-fetch reader between the PC register and
// instruction memory. Issues one read per accepted PC, matches in-order
// responses to their PCs, buffers {pc, inst} pairs and hands them to IF/ID.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : if_fetch_unit_if.master (PC handshake, imem req/rsp, IF/ID output)
module if_fetch_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] pc_mem_q [DEPTH];
    logic [PW-1:0]     pc_wr_q, pc_wr_d, pc_rd_q, pc_rd_d;

    logic [EW-1:0]     buf_mem_q [DEPTH];
    logic [PW-1:0]     buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [CW-1:0]     buf_cnt_q, buf_cnt_d;

    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;

    logic [CW:0]       used;
    logic              credit, accept, rsp_take, keep, pop, id_valid;

    always_comb begin
        // Credit counts every fetch that will eventually occupy a buffer slot,
        // including ones already marked for dropping; uses pre-edge state only.
        used     = {1'b0, outst_q} + {1'b0, buf_cnt_q};
        credit   = used < (CW+1)'(DEPTH);

        bus.imem_req_valid = !rst && !bus.flush && credit;
        bus.imem_req_addr  = bus.curr_pc;
        accept             = bus.imem_req_valid && bus.imem_req_ready;
        bus.pc_hazarded    = rst || (!accept && !bus.flush);

        // Responses with nothing outstanding are ignored.
        rsp_take = !rst && bus.imem_rsp_valid && (outst_q != '0);
        // A response arriving in a flush cycle is consumed but discarded.
        keep     = rsp_take && (drop_q == '0) && !bus.flush;

        id_valid     = !rst && (buf_cnt_q != '0);
        pop          = id_valid && bus.id_ready;
        bus.id_valid = id_valid;
        {bus.id_pc, bus.id_inst} = id_valid ? buf_mem_q[buf_rd_q] : '0;

        pc_wr_d = pc_wr_q + PW'(accept);
        pc_rd_d = pc_rd_q + PW'(rsp_take);
        outst_d = outst_q + CW'(accept) - CW'(rsp_take);

        drop_d = drop_q;
        if (bus.flush) begin
            // Everything still outstanding after this edge belongs to the old path.
            drop_d = outst_q - CW'(rsp_take);
        end else if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        buf_wr_d  = buf_wr_q + PW'(keep);
        buf_rd_d  = buf_rd_q + PW'(pop);
        buf_cnt_d = buf_cnt_q + CW'(keep) - CW'(pop);
        if (bus.flush) begin
            buf_rd_d  = buf_wr_q;
            buf_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_wr_q   <= '0;
            pc_rd_q   <= '0;
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            buf_cnt_q <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            pc_wr_q   <= pc_wr_d;
            pc_rd_q   <= pc_rd_d;
            buf_wr_q  <= buf_wr_d;
            buf_rd_q  <= buf_rd_d;
            buf_cnt_q <= buf_cnt_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem_q[pc_wr_q] <= bus.curr_pc;
        end
        if (keep) begin
            buf_mem_q[buf_wr_q] <= {pc_mem_q[pc_rd_q], bus.imem_rsp_data};
        end
    end

    rsp_needs_request: assert property (
        @(posedge clk) disable iff (rst) bus.imem_rsp_valid |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit. The bench plays the PC
// register and an in-order instruction memory, keeps a queue-level model of
// fetches in flight and delivered entries, and compares every cycle.
module tb_if_fetch_unit;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] pc; int due; bit drop; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    fl_t         inflight[$];
    ent_t        outq[$];
    logic [31:0] dut_dlog[$];
    logic [31:0] dut_ilog[$];
    logic [31:0] dut_alog[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_idv = -1;
    logic        flush, rdy, idr, rsp_en;
    logic [31:0] tgt, pc_reg;
    int          lat;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic e_rv, e_acc, e_hz, e_idv, e_pop, rsp;
        fl_t  f;
        bus.flush          = flush;
        bus.imem_req_ready = rdy;
        bus.id_ready       = idr;
        bus.curr_pc        = pc_reg;
        rsp = 1'b0;
        if (!rst && rsp_en && inflight.size() > 0) begin
            if (inflight[0].due <= cyc) rsp = 1'b1;
        end
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? inst_of(inflight[0].pc) : 32'h0;
        #1;
        e_rv  = !rst && !flush && (inflight.size() + outq.size() < DEPTH);
        e_acc = e_rv && rdy;
        e_hz  = rst || (!e_acc && !flush);
        e_idv = !rst && (outq.size() > 0);
        e_pop = e_idv && idr;
        chk("req_valid", bus.imem_req_valid, e_rv);
        chk("pc_hazarded", bus.pc_hazarded, e_hz);
        chk("id_valid", bus.id_valid, e_idv);
        chk("req_addr", bus.imem_req_addr, pc_reg);
        if (e_idv) begin
            chk("id_pc", bus.id_pc, outq[0].pc);
            chk("id_inst", bus.id_inst, outq[0].inst);
        end
        if (rst) begin
            chk("rst_id_pc", bus.id_pc, 0);
            chk("rst_id_inst", bus.id_inst, 0);
        end
        if (bus.id_valid && first_idv < 0) first_idv = cyc;
        if (bus.id_valid && idr) begin
            dut_dlog.push_back(bus.id_pc);
            dut_ilog.push_back(bus.id_inst);
        end
        if (bus.imem_req_valid && rdy) dut_alog.push_back(bus.imem_req_addr);
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            outq.delete();
            pc_reg = 32'h0;
        end else begin
            if (e_pop) outq.pop_front();
            if (rsp) begin
                f = inflight.pop_front();
                if (!f.drop && !flush) outq.push_back('{pc: f.pc, inst: inst_of(f.pc)});
            end
            if (flush) begin
                outq.delete();
                foreach (inflight[i]) inflight[i].drop = 1'b1;
            end
            if (e_acc) begin
                inflight.push_back('{pc: pc_reg, due: cyc + lat, drop: 1'b0});
                if (first_acc < 0) first_acc = cyc;
            end
            if (flush) pc_reg = tgt;
            else if (!e_hz) pc_reg = pc_reg + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int k, n, cnt;
        rst = 1'b1; flush = 1'b0; tgt = '0; rdy = 1'b1; idr = 1'b1;
        rsp_en = 1'b1; lat = 1; pc_reg = '0;
        @(negedge clk);
        repeat (2) cycle();
        rst = 1'b0;
        first_acc = -1; first_idv = -1;

        // 1: streaming fetch with 1-cycle memory
        repeat (10) cycle();
        chk("t1_first_latency", 64'(first_idv - first_acc), 2);
        chk("t1_count_ge3", dut_dlog.size() >= 3, 1);
        if (dut_dlog.size() >= 3) begin
            chk("t1_pc0", dut_dlog[0], 32'h0);
            chk("t1_pc1", dut_dlog[1], 32'h4);
            chk("t1_pc2", dut_dlog[2], 32'h8);
            chk("t1_inst1", dut_ilog[1], 32'hC0DE_0004);
        end

        // 2: memory backpressure at 0x10
        flush = 1'b1; tgt = 32'h10; rdy = 1'b0;
        cycle();
        flush = 1'b0;
        k = dut_alog.size();
        repeat (3) cycle();
        chk("t2_no_accept_stalled", dut_alog.size() - k, 0);
        rdy = 1'b1;
        repeat (6) cycle();
        cnt = 0;
        for (int i = k; i < dut_alog.size(); i++) if (dut_alog[i] == 32'h10) cnt++;
        chk("t2_one_req_0x10", cnt, 1);

        // 3: IF/ID stall then drain
        idr = 1'b0;
        repeat (8) cycle();
        chk("t3_id_valid_held", bus.id_valid, 1);
        chk("t3_req_blocked", bus.imem_req_valid, 0);
        chk("t3_hazard", bus.pc_hazarded, 1);
        k = dut_dlog.size();
        idr = 1'b1;
        repeat (12) cycle();
        chk("t3_drained_ge2", dut_dlog.size() - k >= 2, 1);
        cnt = 0;
        for (int i = (k > 0 ? k : 1); i < dut_dlog.size(); i++)
            if (dut_dlog[i] != dut_dlog[i-1] + 32'd4) cnt++;
        chk("t3_contiguous", cnt, 0);

        // 4: flush with 0x20/0x24 in flight, 3-cycle responses
        flush = 1'b1; tgt = 32'h20; rdy = 1'b0;
        cycle();
        flush = 1'b0;
        n = 0;
        while ((inflight.size() > 0 || outq.size() > 0) && n < 20) begin cycle(); n++; end
        chk("t4_drain_bound", n < 20, 1);
        lat = 3; rdy = 1'b1;
        n = 0;
        while (inflight.size() < 2 && n < 10) begin cycle(); n++; end
        chk("t4_fill_bound", n < 10, 1);
        k = dut_dlog.size();
        flush = 1'b1; tgt = 32'h100;
        cycle();
        flush = 1'b0; lat = 1;
        repeat (12) cycle();
        chk("t4_delivered_after", dut_dlog.size() > k, 1);
        if (dut_dlog.size() > k) begin
            chk("t4_first_pc", dut_dlog[k], 32'h100);
            chk("t4_first_inst", dut_ilog[k], 32'hC0DE_0100);
        end
        cnt = 0;
        for (int i = k; i < dut_dlog.size(); i++)
            if (dut_dlog[i] == 32'h20 || dut_dlog[i] == 32'h24) cnt++;
        chk("t4_no_stale", cnt, 0);

        // 5: random concurrency of accept/response/pop/flush
        for (int i = 0; i < 100; i++) begin
            rdy    = 1'($urandom_range(0, 1));
            idr    = 1'($urandom_range(0, 1));
            rsp_en = 1'($urandom_range(0, 1));
            flush  = ($urandom_range(0, 15) == 0);
            tgt    = $urandom & 32'h0000_FFFC;
            cycle();
        end
        flush = 1'b0; rdy = 1'b1; rsp_en = 1'b1;

        // 6: reset with two entries buffered
        idr = 1'b0;
        n = 0;
        while (outq.size() < 2 && n < 20) begin cycle(); n++; end
        chk("t6_fill_bound", n < 20, 1);
        rst = 1'b1;
        cycle();
        chk("t6_rst_id_valid", bus.id_valid, 0);
        chk("t6_rst_req_valid", bus.imem_req_valid, 0);
        chk("t6_rst_hazard", bus.pc_hazarded, 1);
        rst = 1'b0; idr = 1'b1;
        k = dut_alog.size();
        repeat (6) cycle();
        chk("t6_restart_any", dut_alog.size() > k, 1);
        if (dut_alog.size() > k) chk("t6_restart_pc", dut_alog[k], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
